uart_cmd_responder: RTL and testbench
=====================================

// Module: uart_cmd_responder
// PURPOSE
//  Host-side end of the UART byte stream: consumes bytes from uart_phy_rxd, decodes
//  fixed-length register commands, runs one 8-bit access on a simple memory-mapped
//  master port, and returns response bytes to uart_phy_txd.
//  Sits between the two UART phys and an on-chip register bus.
// PARAMETERS
//  CMD_WRITE       8'h57     command byte for a write ('W')
//  CMD_READ        8'h52     command byte for a read ('R')
//  TIMEOUT_CYCLES  5000000   inter-byte abort limit in clk cycles (UART_CMDRSP_TIMEOUT_EN only)
// PORTS
//  clk            in   1   clock, all logic on rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  in_ready       out  1   ST sink ready (to uart_phy_rxd out_ready)
//  in_valid       in   1   ST sink valid
//  in_data        in   8   received byte
//  in_error       in   2   [0] overflow, [1] framing; qualified by in_valid
//  out_ready      in   1   ST source ready (from uart_phy_txd in_ready)
//  out_valid      out  1   ST source valid
//  out_data       out  8   response byte
//  bus_address    out  16  register address
//  bus_write      out  1   write strobe, held until !bus_waitrequest
//  bus_read       out  1   read strobe, held until !bus_waitrequest
//  bus_writedata  out  8   write data
//  bus_readdata   in   8   read data, valid in the cycle bus_read && !bus_waitrequest
//  bus_waitrequest in  1   slave stall
// BEHAVIOUR
//  Reset: in_ready=0, out_valid=0, out_data=8'h00, bus_address=16'h0000, bus_read=0,
//   bus_write=0, bus_writedata=8'h00; FSM=IDLE; partial frame discarded.
//  Frames: write = W, ADDR_H, ADDR_L, DATA -> response 8'h06 (ACK).
//          read  = R, ADDR_H, ADDR_L       -> response 8'h06, then read byte.
//  Byte accepted when in_valid && in_ready. in_ready=1 only in IDLE/ADDR_H/ADDR_L/DATA.
//  FSM: IDLE -(W|R)-> ADDR_H -> ADDR_L -(R)-> BUS_RD / -(W)-> DATA -> BUS_WR;
//   BUS_WR/BUS_RD -(!bus_waitrequest)-> RSP_ACK; RSP_ACK -(out_ready, W)-> IDLE,
//   -(out_ready, R)-> RSP_DATA -(out_ready)-> IDLE; RSP_NAK -(out_ready)-> IDLE.
//  Unknown command byte in IDLE -> RSP_NAK (out_data=8'h15).
//  in_error[1] on any accepted byte -> byte dropped, frame aborted, RSP_NAK.
//  in_error[0] alone is ignored; the byte is used normally.
//  bus_read/bus_write asserted the cycle after the last frame byte is accepted, held
//   with stable address/data until sampled !bus_waitrequest; readdata latched then.
//  Min latency: last byte accept -> bus strobe 1 cycle; zero-wait access -> out_valid next cycle.
//  out_valid/out_data held stable until out_ready; no new byte accepted during BUS_*/RSP_*.
//  Unbounded bus_waitrequest stalls indefinitely (no bus timeout).
//  Back-to-back frames: IDLE accepts the next command in the cycle after the final response handshake.
// CONFIGURATION
//  UART_CMDRSP_TIMEOUT_EN defined: in ADDR_H/ADDR_L/DATA a counter reloads on each accepted
//   byte and counts clk; at TIMEOUT_CYCLES without a byte -> frame aborted, RSP_NAK.
//  Undefined: no counter; a partial frame waits forever for the next byte.
// STRUCTURE
//  Shared include uart_cmd_defs.vh: ACK 8'h06, NAK 8'h15, default command codes,
//   FSM state encodings.
//  One sub-module, uart_cmd_timeout: 24-bit reload/down counter with expire pulse,
//   instantiated only under UART_CMDRSP_TIMEOUT_EN.
// TESTING
//  W,12h,34h,A5h, waitrequest=0 -> bus_write with addr 1234h, data A5h for 1 cycle; out 06h.
//  R,00h,10h, readdata=3Ch, waitrequest high 3 cycles -> bus_read held 4 cycles; out 06h,3Ch.
//  Byte 41h in IDLE -> out 15h, no bus strobe; following W frame executes normally.
//  W,12h with in_error=2'b10 on ADDR_L -> out 15h, no bus strobe.
//  out_ready low 20 cycles during read response -> out_valid, out_data=06h held; in_ready=0.
//  reset_n low mid-frame (after W,12h) -> all outputs at reset values; next R frame completes.
//  With macro, TIMEOUT_CYCLES=100: W,12h then idle 100 cycles -> out 15h; without macro, no output.

Source files
------------

// File: rtl/uart_cmd_responder_pkg.sv
// Shared constants, FSM encoding and frame record for the UART command responder.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package uart_cmd_responder_pkg;

  localparam logic [7:0] RSP_ACK_BYTE  = 8'h06;
  localparam logic [7:0] RSP_NAK_BYTE  = 8'h15;
  localparam logic [7:0] CMD_WRITE_DEF = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ_DEF  = 8'h52;  // 'R'

  // in_error bit that poisons a byte; the overflow bit is informational only.
  localparam int ERR_FRAMING = 1;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR_H   = 4'd1,
    ST_ADDR_L   = 4'd2,
    ST_DATA     = 4'd3,
    ST_BUS_WR   = 4'd4,
    ST_BUS_RD   = 4'd5,
    ST_RSP_ACK  = 4'd6,
    ST_RSP_DATA = 4'd7,
    ST_RSP_NAK  = 4'd8
  } state_t;

  // Decoded command being assembled / executed.
  typedef struct packed {
    logic        is_read;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } frame_t;

  // States in which a partially received frame is waiting for its next byte.
  function automatic logic mid_frame(state_t s);
    return (s == ST_ADDR_H) || (s == ST_ADDR_L) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte watchdog: 24-bit down counter reloaded on every accepted byte.
// Latency: o_expire is combinational once the count has run down to zero.
// Backpressure: none; counts only while i_run is high, holds otherwise.
//
// Ports:
//   clk, reset_n  clock / async active-low reset
//   i_load        reload the counter (a byte was accepted)
//   i_run         count this cycle (a frame is in progress)
//   o_expire      high while running with the counter exhausted
//
// Only built with UART_CMDRSP_TIMEOUT_EN; without it nothing instantiates it.
`ifdef UART_CMDRSP_TIMEOUT_EN
module uart_cmd_timeout #(
  parameter logic [23:0] LOAD_VAL = 24'd4999999
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_load,
  input  logic i_run,
  output logic o_expire
);

  logic [23:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= LOAD_VAL;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_run && (r_count != 24'd0)) begin
      r_count <= r_count - 24'd1;
    end
  end

  assign o_expire = i_run && (r_count == 24'd0);

endmodule
`endif

// File: rtl/uart_cmd_responder.sv
// UART command responder: decodes W/R register frames, runs one 8-bit bus access, returns ACK/NAK/data.
// Latency: last frame byte -> bus strobe 1 cycle; zero-wait access -> out_valid the next cycle.
// Backpressure: in_ready low outside frame reception; out_valid/out_data held until out_ready.
//
// Ports:
//   clk, reset_n                      clock / async active-low reset
//   in_ready/in_valid/in_data/in_error  byte sink from the receive phy (in_error[1] = framing)
//   out_ready/out_valid/out_data        byte source to the transmit phy
//   bus_*                               8-bit memory-mapped master, stalls on bus_waitrequest
//
// Optional feature: define UART_CMDRSP_TIMEOUT_EN to abort a partial frame after
// TIMEOUT_CYCLES clocks without a byte (answered with NAK).
module uart_cmd_responder
    import uart_cmd_responder_pkg::*;
#(
    parameter logic [7:0]  CMD_WRITE      = CMD_WRITE_DEF,
    parameter logic [7:0]  CMD_READ       = CMD_READ_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        in_ready,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic [1:0]  in_error,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic [15:0] bus_address,
    output logic        bus_write,
    output logic        bus_read,
    output logic [7:0]  bus_writedata,
    input  logic [7:0]  bus_readdata,
    input  logic        bus_waitrequest
);

    state_t      r_state;
    frame_t      r_frame;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [7:0]  r_out_data;
    logic        r_bus_read;
    logic        r_bus_write;
    logic [7:0]  r_rdata;

    logic w_accept;
    logic w_frame_err;
    logic w_timeout;
    logic w_unused_overflow;

    assign w_accept    = in_valid && r_in_ready;
    assign w_frame_err = in_error[ERR_FRAMING];
    // Overflow alone does not affect the byte, so it is deliberately not consumed.
    assign w_unused_overflow = in_error[0];

`ifdef UART_CMDRSP_TIMEOUT_EN
    uart_cmd_timeout #(
        .LOAD_VAL (24'(TIMEOUT_CYCLES - 1))
    ) u_timeout (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_load   (w_accept),
        .i_run    (mid_frame(r_state)),
        .o_expire (w_timeout)
    );
`else
    // A partial frame waits indefinitely for its next byte.
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_frame     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_bus_read  <= 1'b0;
            r_bus_write <= 1'b0;
            r_rdata     <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // in_ready comes up one cycle after reset release.
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        if (!w_frame_err && (in_data == CMD_WRITE)) begin
                            r_frame.is_read <= 1'b0;
                            r_state         <= ST_ADDR_H;
                        end else if (!w_frame_err && (in_data == CMD_READ)) begin
                            r_frame.is_read <= 1'b1;
                            r_state         <= ST_ADDR_H;
                        end else begin
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_data  <= RSP_NAK_BYTE;
                            r_state     <= ST_RSP_NAK;
                        end
                    end
                end

                ST_ADDR_H: begin
                    if (w_accept && !w_frame_err) begin
                        r_frame.addr[15:8] <= in_data;
                        r_state            <= ST_ADDR_L;
                    end else if (w_accept || w_timeout) begin
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= RSP_NAK_BYTE;
                        r_state     <= ST_RSP_NAK;
                    end
                end

                ST_ADDR_L: begin
                    if (w_accept && !w_frame_err) begin
                        r_frame.addr[7:0] <= in_data;
                        if (r_frame.is_read) begin
                            r_in_ready <= 1'b0;
                            r_bus_read <= 1'b1;
                            r_state    <= ST_BUS_RD;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end else if (w_accept || w_timeout) begin
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= RSP_NAK_BYTE;
                        r_state     <= ST_RSP_NAK;
                    end
                end

                ST_DATA: begin
                    if (w_accept && !w_frame_err) begin
                        r_frame.wdata <= in_data;
                        r_in_ready    <= 1'b0;
                        r_bus_write   <= 1'b1;
                        r_state       <= ST_BUS_WR;
                    end else if (w_accept || w_timeout) begin
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= RSP_NAK_BYTE;
                        r_state     <= ST_RSP_NAK;
                    end
                end

                ST_BUS_WR: begin
                    if (!bus_waitrequest) begin
                        r_bus_write <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= RSP_ACK_BYTE;
                        r_state     <= ST_RSP_ACK;
                    end
                end

                ST_BUS_RD: begin
                    if (!bus_waitrequest) begin
                        // readdata is only valid in the completing cycle; keep it for RSP_DATA.
                        r_bus_read  <= 1'b0;
                        r_rdata     <= bus_readdata;
                        r_out_valid <= 1'b1;
                        r_out_data  <= RSP_ACK_BYTE;
                        r_state     <= ST_RSP_ACK;
                    end
                end

                ST_RSP_ACK: begin
                    if (out_ready) begin
                        if (r_frame.is_read) begin
                            r_out_data <= r_rdata;
                            r_state    <= ST_RSP_DATA;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end
                end

                ST_RSP_DATA, ST_RSP_NAK: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_bus_read  <= 1'b0;
                    r_bus_write <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign bus_address   = r_frame.addr;
    assign bus_writedata = r_frame.wdata;
    assign bus_read      = r_bus_read;
    assign bus_write     = r_bus_write;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder: directed scenarios followed by randomized frames,
// checked against a frame-level reference model (expected response bytes, bus
// transactions and a reference memory image).
module tb_uart_cmd_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_ready;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic [1:0]  in_error = 2'b00;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [15:0] bus_address;
    logic        bus_write;
    logic        bus_read;
    logic [7:0]  bus_writedata;
    logic [7:0]  bus_readdata = 8'h00;
    logic        bus_waitrequest = 1'b0;

    always #5 clk = ~clk;

    uart_cmd_responder #(
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_ready        (in_ready),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_error        (in_error),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .bus_address     (bus_address),
        .bus_write       (bus_write),
        .bus_read        (bus_read),
        .bus_writedata   (bus_writedata),
        .bus_readdata    (bus_readdata),
        .bus_waitrequest (bus_waitrequest)
    );

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  dat;
        int          cyc;
    } txn_t;

    int n_pass = 0;
    int n_tot  = 0;

    logic [7:0] exp_rsp[$];
    logic [7:0] got_rsp[$];
    txn_t       exp_txn[$];
    txn_t       got_txn[$];
    logic [7:0] ref_mem[int];
    logic [7:0] bus_mem[int];

    int cfg_wait   = 0;
    int sink_pct   = 10;
    bit sink_hold  = 1'b0;
    int stable_err = 0;

    function automatic logic [7:0] init_val(logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hC3;
    endfunction

    function automatic logic [7:0] ref_rd(logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Bus slave: memory image with a programmable number of wait cycles per access.
    initial begin
        bit          in_acc;
        int          wl;
        int          cyc;
        logic [15:0] a0;
        logic [7:0]  d0;
        txn_t        t;
        in_acc = 1'b0;
        wl = 0;
        cyc = 0;
        a0 = '0;
        d0 = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                in_acc = 1'b0;
                bus_waitrequest = 1'b0;
            end else if (bus_read || bus_write) begin
                if (!in_acc) begin
                    in_acc = 1'b1;
                    wl = cfg_wait;
                    cyc = 0;
                    a0 = bus_address;
                    d0 = bus_writedata;
                end
                cyc++;
                if (bus_address !== a0 || (bus_write && bus_writedata !== d0)) stable_err++;
                if (wl > 0) begin
                    wl--;
                    bus_waitrequest = 1'b1;
                    bus_readdata = 8'($urandom);
                end else begin
                    bus_waitrequest = 1'b0;
                    t.wr = bus_write;
                    t.addr = bus_address;
                    t.cyc = cyc;
                    if (bus_write) begin
                        t.dat = bus_writedata;
                        bus_mem[int'(bus_address)] = bus_writedata;
                    end else begin
                        t.dat = bus_mem.exists(int'(bus_address)) ? bus_mem[int'(bus_address)]
                                                                  : init_val(bus_address);
                        bus_readdata = t.dat;
                    end
                    got_txn.push_back(t);
                    in_acc = 1'b0;
                end
            end else begin
                bus_waitrequest = 1'($urandom_range(0, 1));
                bus_readdata = 8'($urandom);
            end
        end
    end

    // Response sink: out_ready chosen per cycle; a byte is taken when valid meets ready.
    initial begin
        forever begin
            @(negedge clk);
            out_ready = sink_hold ? 1'b0 : ($urandom_range(0, 9) < sink_pct);
            if (reset_n && out_valid && out_ready) got_rsp.push_back(out_data);
        end
    end

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks so far %0d/%0d", n_pass, n_tot);
        $fatal(1);
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send_byte(logic [7:0] b, logic [1:0] e);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_error = e;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("in_ready_wait", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_error = 2'b00;
    endtask

    // Reference model: expected responses and bus activity for one frame.
    // kind 0 = write, 1 = read, 2 = unknown command; err = framing error somewhere in it.
    task automatic model(int kind, logic [15:0] addr, logic [7:0] dat, bit err);
        txn_t t;
        if (err || kind == 2) begin
            exp_rsp.push_back(8'h15);
        end else if (kind == 0) begin
            exp_rsp.push_back(8'h06);
            t = '{1'b1, addr, dat, cfg_wait + 1};
            exp_txn.push_back(t);
            ref_mem[int'(addr)] = dat;
        end else begin
            exp_rsp.push_back(8'h06);
            exp_rsp.push_back(ref_rd(addr));
            t = '{1'b0, addr, ref_rd(addr), cfg_wait + 1};
            exp_txn.push_back(t);
        end
    endtask

    task automatic clear_queues();
        exp_rsp.delete();
        got_rsp.delete();
        exp_txn.delete();
        got_txn.delete();
    endtask

    task automatic finish_frame();
        int n;
        n = 0;
        while ((got_rsp.size() < exp_rsp.size() || !in_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_count", got_rsp.size(), exp_rsp.size());
        for (int i = 0; i < exp_rsp.size() && i < got_rsp.size(); i++)
            chk("rsp_byte", 32'(got_rsp[i]), 32'(exp_rsp[i]));
        chk("txn_count", got_txn.size(), exp_txn.size());
        for (int i = 0; i < exp_txn.size() && i < got_txn.size(); i++) begin
            chk("txn_wr",   32'(got_txn[i].wr),   32'(exp_txn[i].wr));
            chk("txn_addr", 32'(got_txn[i].addr), 32'(exp_txn[i].addr));
            chk("txn_dat",  32'(got_txn[i].dat),  32'(exp_txn[i].dat));
            chk("txn_cyc",  got_txn[i].cyc,       exp_txn[i].cyc);
        end
        clear_queues();
    endtask

    // kind 2 sends dat as the (unknown) command byte; err_idx < 0 means no framing error.
    task automatic run_frame(int kind, logic [15:0] addr, logic [7:0] dat, int err_idx, int gmax);
        logic [7:0] fb[4];
        int len;
        int eidx;
        fb[0] = (kind == 0) ? 8'h57 : (kind == 1) ? 8'h52 : dat;
        fb[1] = addr[15:8];
        fb[2] = addr[7:0];
        fb[3] = dat;
        len = (kind == 0) ? 4 : (kind == 1) ? 3 : 1;
        eidx = (err_idx >= len) ? -1 : err_idx;
        for (int i = 0; i < len; i++) begin
            if (eidx == i) begin
                send_byte(fb[i], {1'b1, 1'($urandom)});
                break;
            end
            send_byte(fb[i], {1'b0, 1'($urandom)});
            repeat ($urandom_range(0, gmax)) @(negedge clk);
        end
        model(kind, addr, dat, eidx >= 0);
        finish_frame();
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready",  32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data), 0);
        chk("rst_bus_addr",  32'(bus_address), 0);
        chk("rst_bus_read",  32'(bus_read), 0);
        chk("rst_bus_write", 32'(bus_write), 0);
        chk("rst_bus_wdata", 32'(bus_writedata), 0);
    endtask

    initial begin
        int          n;
        int          hold_ok;
        int          kind;
        int          eidx;
        logic [15:0] a;
        logic [7:0]  d;

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 1);

        // Zero-wait write with latency checks
        sink_pct = 10;
        cfg_wait = 0;
        send_byte(8'h57, 2'b00);
        send_byte(8'h12, 2'b00);
        send_byte(8'h34, 2'b00);
        send_byte(8'hA5, 2'b00);
        chk("wr_strobe",    32'(bus_write), 1);
        chk("wr_no_read",   32'(bus_read), 0);
        chk("wr_addr",      32'(bus_address), 'h1234);
        chk("wr_data",      32'(bus_writedata), 'hA5);
        chk("wr_in_ready",  32'(in_ready), 0);
        @(negedge clk);
        chk("wr_ack_valid", 32'(out_valid), 1);
        chk("wr_ack_data",  32'(out_data), 'h06);
        chk("wr_strobe_end", 32'(bus_write), 0);
        model(0, 16'h1234, 8'hA5, 1'b0);
        finish_frame();

        // Read with three stall cycles
        ref_mem[16'h0010] = 8'h3C;
        bus_mem[16'h0010] = 8'h3C;
        cfg_wait = 3;
        run_frame(1, 16'h0010, 8'h00, -1, 0);

        // Unknown command, then a normal write
        cfg_wait = 0;
        run_frame(2, 16'h0000, 8'h41, -1, 0);
        run_frame(0, 16'h2001, 8'h5E, -1, 2);

        // Framing error on ADDR_L
        run_frame(0, 16'h1234, 8'h99, 2, 1);

        // Response held while out_ready stays low
        sink_hold = 1'b1;
        send_byte(8'h52, 2'b00);
        send_byte(8'h12, 2'b00);
        send_byte(8'h34, 2'b00);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        hold_ok = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_data === 8'h06 && in_ready === 1'b0) hold_ok++;
        end
        chk("hold_20_cycles", hold_ok, 20);
        sink_hold = 1'b0;
        model(1, 16'h1234, 8'h00, 1'b0);
        finish_frame();

        // Reset in the middle of a frame
        send_byte(8'h57, 2'b00);
        send_byte(8'h12, 2'b00);
        reset_n = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk);
        clear_queues();
        reset_n = 1'b1;
        @(negedge clk);
        run_frame(1, 16'h2001, 8'h00, -1, 1);

        // Stalled partial frame
        send_byte(8'h57, 2'b00);
        send_byte(8'h12, 2'b00);
`ifdef UART_CMDRSP_TIMEOUT_EN
        exp_rsp.push_back(8'h15);
        finish_frame();
`else
        repeat (100) @(negedge clk);
        chk("stall_no_rsp",   got_rsp.size(), 0);
        chk("stall_no_valid", 32'(out_valid), 0);
        chk("stall_in_ready", 32'(in_ready), 1);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        clear_queues();
        reset_n = 1'b1;
        @(negedge clk);
`endif

        // Randomized frames
        sink_pct = 7;
        repeat (60) begin
            kind = $urandom_range(0, 5);
            kind = (kind <= 2) ? 0 : (kind <= 4) ? 1 : 2;
            eidx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            cfg_wait = $urandom_range(0, 4);
            a = {8'h40, 4'h0, 4'($urandom)};
            d = 8'($urandom);
            if (kind == 2) begin
                while (d == 8'h57 || d == 8'h52) d = 8'($urandom);
            end
            run_frame(kind, a, d, eidx, 3);
        end

        chk("bus_stable", stable_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
